// File: rtl/pll_lock_sequencer_if.sv
// Groups the PLL control/status signals between the lock sequencer and its consumers.
// Latency: none (wires only).
// Backpressure: none; every signal is a level.
interface pll_lock_sequencer_if #(
  parameter int CNT_W = 8
) ();

  logic             pll_lock;       // PLL LOCK output, async to the sequencer clock
  logic             pll_reset;      // PLL RESET, active-high
  logic             sys_rst_n;      // reset for the PLL-clocked domain, active-low
  logic             locked;         // high while the sequencer is in RUN
  logic [CNT_W-1:0] loss_count;     // RUN -> lock-loss events, saturating
  logic [CNT_W-1:0] timeout_count;  // WAIT_LOCK timeouts, saturating
  logic [1:0]       state_o;        // 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN

  // Sequencer side: watches lock, drives everything else.
  modport master (
    input  pll_lock,
    output pll_reset,
    output sys_rst_n,
    output locked,
    output loss_count,
    output timeout_count,
    output state_o
  );

  // Consumer side: PLL wrapper / status logic.
  modport slave (
    output pll_lock,
    input  pll_reset,
    input  sys_rst_n,
    input  locked,
    input  loss_count,
    input  timeout_count,
    input  state_o
  );

endinterface

// File: rtl/pll_lock_sequencer.sv
// Pulses PLL reset, waits for a stable lock, then releases the PLL-domain reset.
// Latency: lock loss reaches sys_rst_n 3 clk edges after pll_lock falls (2 sync + 1 FSM).
// Backpressure: none; runs on the reference clock so it keeps ticking while unlocked.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pll_lock_sequencer_if.master      bus
);

  // Counter must hold the largest terminal value of any state.
  localparam int MAX_A    = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C    = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_BITS = $clog2(MAX_C) + 1;

  localparam logic [CNT_BITS-1:0] RST_LAST    = CNT_BITS'(RST_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_BITS-1:0] STABLE_LAST = CNT_BITS'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  // Two-flop synchroniser for the asynchronous lock indication.
  logic lock_meta_q, lock_meta_d;
  logic lock_s_q, lock_s_d;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    loss_q, loss_d;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic                pll_reset_q, pll_reset_d;
  logic                sys_rst_n_q, sys_rst_n_d;
  logic                locked_q, locked_d;

  // Synchroniser next-state: shift pll_lock through two stages.
  always_comb begin
    lock_meta_d = bus.pll_lock;
    lock_s_d    = lock_meta_q;
  end

  // Synchroniser flops, cleared to "unlocked" on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
    end
  end

  // FSM next-state, cycle counter, saturating debug counters and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    loss_d  = loss_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle takes priority over re-pulsing.
        if (lock_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
        end
      end
      S_STABLE: begin
        // A dropout here just restarts the wait; it is not a loss or a timeout.
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s_q) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered decodes of the next state, so they track state_q exactly.
    pll_reset_d = (state_d == S_RESET_PLL);
    sys_rst_n_d = (state_d == S_RUN);
    locked_d    = (state_d == S_RUN);
  end

  // FSM state, counters and registered outputs; reset forces PLL reset and holds the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      loss_q      <= '0;
      tmo_q       <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      tmo_q       <= tmo_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.pll_reset     = pll_reset_q;
  assign bus.sys_rst_n     = sys_rst_n_q;
  assign bus.locked        = locked_q;
  assign bus.loss_count    = loss_q;
  assign bus.timeout_count = tmo_q;
  assign bus.state_o       = state_q;

endmodule
